// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack memory port,
// buffers them in a small prefetch FIFO and hands {instr, pc+4} to decode.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pcinc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [1:0]  dbg_state_o
);

   // Handshakes: decode takes the FIFO head on any edge where out_valid && out_ready;
   // memory completes a request on any edge where mem_req && mem_ack, and mem_req/mem_addr
   // stay unchanged until that edge.

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DISCARD = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       instr_q [FIFO_DEPTH];
   logic [31:0]       pcinc_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  count_after_push;

   logic              pop;
   logic              push;
   logic              flush;
   logic [31:0]       pc_plus4;
   logic [31:0]       target_aligned;
   logic              unused_target_lsbs;

   assign target_aligned     = {redirect_target[31:2], 2'b00};
   assign unused_target_lsbs = ^redirect_target[1:0];
   assign pc_plus4           = pc_q + 32'd4;

   assign out_valid = (count_q != '0);
   assign out_instr = instr_q[rd_ptr_q];
   assign out_pcinc = pcinc_q[rd_ptr_q];
   assign pop       = out_valid && out_ready;

   assign mem_req     = (state_q != ST_IDLE);
   assign mem_addr    = addr_q;
   assign dbg_state_o = state_q;

   // Occupancy if this cycle's ack is pushed; decides whether another fetch fits.
   assign count_after_push = count_q + CNT_W'(1) - CNT_W'(pop);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      flush   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (redirect_valid) begin
               flush   = 1'b1;
               pc_d    = target_aligned;
               state_d = ST_FETCH;
            end else if (count_q < DEPTH_C) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            if (redirect_valid) begin
               flush   = 1'b1;
               pc_d    = target_aligned;
               // Without an ack the old request is still open and must be drained.
               state_d = mem_ack ? ST_FETCH : ST_DISCARD;
            end else if (mem_ack) begin
               push    = 1'b1;
               pc_d    = pc_plus4;
               state_d = (count_after_push < DEPTH_C) ? ST_FETCH : ST_IDLE;
            end
         end

         ST_DISCARD: begin
            if (redirect_valid) begin
               flush = 1'b1;
               pc_d  = target_aligned;
            end else if (mem_ack) begin
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      // The memory address only follows the PC when no abandoned request is open.
      addr_d = (state_d == ST_DISCARD) ? addr_q : pc_d;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            instr_q[i] <= '0;
            pcinc_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) begin
               instr_q[wr_ptr_q] <= mem_rdata;
               pcinc_q[wr_ptr_q] <= pc_plus4;
               wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a behavioural memory with programmable ack
// latency and hand-derived cycle-by-cycle expectations for each scenario.
module tb_if_fetch_unit;

   localparam logic [31:0] ST_IDLE    = 32'd0;
   localparam logic [31:0] ST_FETCH   = 32'd1;
   localparam logic [31:0] ST_DISCARD = 32'd2;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pcinc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [1:0]  dbg_state_o;

   int checks   = 0;
   int failures = 0;
   int ack_lat  = 0;
   int ack_cnt  = 0;

   if_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pcinc       (out_pcinc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .dbg_state_o     (dbg_state_o)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] rd(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Memory model: ack_lat==0 ties ack high; otherwise ack in the ack_lat-th request cycle.
   always @(negedge Clk) begin
      mem_rdata = rd(mem_addr);
      if (ack_lat == 0) begin
         mem_ack = 1'b1;
         ack_cnt = 0;
      end else if (!mem_req) begin
         mem_ack = 1'b0;
         ack_cnt = 0;
      end else begin
         ack_cnt = ack_cnt + 1;
         if (ack_cnt >= ack_lat) begin
            mem_ack = 1'b1;
            ack_cnt = 0;
         end else begin
            mem_ack = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge Clk);
      #1;
   endtask

   task automatic hold_reset(input int lat, input logic rdy);
      Reset          = 1'b0;
      ack_lat        = lat;
      out_ready      = rdy;
      redirect_valid = 1'b0;
      step();
      step();
   endtask

   initial begin
      // Reset values, with ack tied high to show it is ignored in reset.
      hold_reset(0, 1'b1);
      check("rst_req",   32'(mem_req),     32'd0);
      check("rst_addr",  mem_addr,         32'h0);
      check("rst_valid", 32'(out_valid),   32'd0);
      check("rst_instr", out_instr,        32'h0);
      check("rst_pcinc", out_pcinc,        32'h0);
      check("rst_state", 32'(dbg_state_o), ST_IDLE);

      // 1: streaming with ack tied high and decode always ready.
      Reset = 1'b1;
      step();
      check("t1_state0", 32'(dbg_state_o), ST_FETCH);
      check("t1_addr0",  mem_addr,         32'h0);
      check("t1_valid0", 32'(out_valid),   32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("t1_addr",  mem_addr,       32'(4 * (k + 1)));
         check("t1_valid", 32'(out_valid), 32'd1);
         check("t1_instr", out_instr,      rd(32'(4 * k)));
         check("t1_pcinc", out_pcinc,      32'(4 * (k + 1)));
      end

      // 2: stall fills the FIFO after two fetches, then resumes in order.
      hold_reset(0, 1'b0);
      Reset = 1'b1;
      step();
      check("t2_addr0", mem_addr, 32'h0);
      step();
      check("t2_req1",  32'(mem_req), 32'd1);
      check("t2_addr1", mem_addr,     32'h4);
      step();
      check("t2_req_full",  32'(mem_req),     32'd0);
      check("t2_state_full", 32'(dbg_state_o), ST_IDLE);
      step();
      check("t2_req_hold",   32'(mem_req),   32'd0);
      check("t2_valid_hold", 32'(out_valid), 32'd1);
      check("t2_instr_hold", out_instr,      rd(32'h0));
      check("t2_pcinc_hold", out_pcinc,      32'h4);
      out_ready = 1'b1;
      step();
      check("t2_req_e5",   32'(mem_req), 32'd0);
      check("t2_instr_e5", out_instr,    rd(32'h4));
      check("t2_pcinc_e5", out_pcinc,    32'h8);
      step();
      check("t2_req_e6",   32'(mem_req),   32'd1);
      check("t2_addr_e6",  mem_addr,       32'h8);
      check("t2_valid_e6", 32'(out_valid), 32'd0);
      step();
      check("t2_valid_e7", 32'(out_valid), 32'd1);
      check("t2_instr_e7", out_instr,      rd(32'h8));
      check("t2_pcinc_e7", out_pcinc,      32'hC);

      // 3: three-cycle memory; address stable, one valid pulse per fetch.
      hold_reset(3, 1'b1);
      Reset = 1'b1;
      step();
      check("t3_addr_e1", mem_addr, 32'h0);
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 2; c++) begin
            step();
            check("t3_addr_wait",  mem_addr,       32'(4 * f));
            check("t3_req_wait",   32'(mem_req),   32'd1);
            check("t3_valid_wait", 32'(out_valid), 32'd0);
         end
         step();
         check("t3_valid", 32'(out_valid), 32'd1);
         check("t3_instr", out_instr,      rd(32'(4 * f)));
         check("t3_pcinc", out_pcinc,      32'(4 * f + 4));
         check("t3_next",  mem_addr,       32'(4 * f + 4));
      end

      // 4: redirect while fetch of 0x10 is outstanding (ack two cycles later).
      hold_reset(4, 1'b1);
      Reset           = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0010;
      step();
      redirect_valid = 1'b0;
      check("t4_state_e1", 32'(dbg_state_o), ST_FETCH);
      check("t4_addr_e1",  mem_addr,         32'h10);
      step();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0103;
      step();
      redirect_valid = 1'b0;
      check("t4_state_disc", 32'(dbg_state_o), ST_DISCARD);
      check("t4_req_disc",   32'(mem_req),     32'd1);
      check("t4_addr_disc",  mem_addr,         32'h10);
      step();
      check("t4_addr_disc2",  mem_addr,       32'h10);
      check("t4_valid_disc2", 32'(out_valid), 32'd0);
      step();
      check("t4_state_new", 32'(dbg_state_o), ST_FETCH);
      check("t4_addr_new",  mem_addr,         32'h100);
      check("t4_valid_new", 32'(out_valid),   32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         check("t4_no_stale", 32'(out_valid), 32'd0);
      end
      step();
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_instr", out_instr,      rd(32'h100));
      check("t4_pcinc", out_pcinc,      32'h104);

      // 5: redirect coincident with ack, FIFO full (one held + one in flight).
      hold_reset(0, 1'b0);
      Reset = 1'b1;
      step();
      step();
      check("t5_valid_pre", 32'(out_valid), 32'd1);
      check("t5_addr_pre",  mem_addr,       32'h4);
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0200;
      out_ready       = 1'b1;
      step();
      redirect_valid = 1'b0;
      check("t5_valid_flush", 32'(out_valid),   32'd0);
      check("t5_addr_tgt",    mem_addr,         32'h200);
      check("t5_state",       32'(dbg_state_o), ST_FETCH);
      step();
      check("t5_valid", 32'(out_valid), 32'd1);
      check("t5_instr", out_instr,      rd(32'h200));
      check("t5_pcinc", out_pcinc,      32'h204);
      step();
      check("t5_instr2", out_instr, rd(32'h204));

      // 6: asynchronous reset mid-fetch, restart at RESET_PC, then PC wrap.
      check("t6_req_before", 32'(mem_req), 32'd1);
      Reset = 1'b0;
      #1;
      check("t6_req_async",   32'(mem_req),   32'd0);
      check("t6_addr_async",  mem_addr,       32'h0);
      check("t6_valid_async", 32'(out_valid), 32'd0);
      step();
      Reset = 1'b1;
      step();
      check("t6_restart_req",  32'(mem_req), 32'd1);
      check("t6_restart_addr", mem_addr,     32'h0);
      step();
      check("t6_restart_instr", out_instr, rd(32'h0));
      check("t6_restart_pcinc", out_pcinc, 32'h4);

      hold_reset(0, 1'b1);
      Reset           = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFF;
      step();
      redirect_valid = 1'b0;
      check("t6_wrap_addr", mem_addr, 32'hFFFF_FFFC);
      step();
      check("t6_wrap_valid", 32'(out_valid), 32'd1);
      check("t6_wrap_instr", out_instr,      rd(32'hFFFF_FFFC));
      check("t6_wrap_pcinc", out_pcinc,      32'h0);
      check("t6_wrap_next",  mem_addr,       32'h0);
      step();
      check("t6_after_instr", out_instr, rd(32'h0));
      check("t6_after_pcinc", out_pcinc, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
